i2s_playback_serializer: RTL
============================

I2S_PLAYBACK_SERIALIZER -- requirements
Module: i2s_playback_serializer

Interface
REQ-001 SHALL have parameter AUDIO_W, default 24: serialized bits per channel, range 16..32; uses the MSBs of each 32-bit half-word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: stereo frames buffered; power of 2, at least 2.
REQ-003 SHALL have port board_clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: playback enable.
REQ-006 SHALL have port s_axis_tvalid, input, 1: frame valid.
REQ-007 SHALL have port s_axis_tready, output, 1: frame accepted when high together with tvalid.
REQ-008 SHALL have port s_axis_tdata, input, 64: [63:32] is the left sample, [31:0] is the right sample.
REQ-009 SHALL have port ac_bclk, input, 1: codec bit clock, asynchronous to board_clk.
REQ-010 SHALL have port ac_pblrc, input, 1: codec playback LR clock; 0 means left.
REQ-011 SHALL have port ac_pbdat, output, 1: serial playback data.
REQ-012 SHALL have port underrun, output, 1: one-cycle pulse when a frame is started with the FIFO empty.

Function
REQ-013 SHALL pass ac_bclk and ac_pblrc through 2-flop synchronizers, then detect bclk falling edges (bfe) as 1->0 transitions of the synchronized bclk.
REQ-014 SHALL drive s_axis_tready = en && !fifo_full; a push occurs on tvalid && tready.
REQ-015 SHALL use FIFO pointers of width log2(FIFO_DEPTH)+1 that wrap modulo 2*FIFO_DEPTH; full when the MSBs differ and the LSBs are equal.
REQ-016 SHALL sample the synchronized lrclk on each bfe, and SHALL treat a difference from the previous sample as a channel start.
REQ-017 SHALL use a state machine with states IDLE, ARM, SHIFT and PAD.
REQ-018 IDLE: SHALL drive ac_pbdat 0; SHALL go to ARM on the first left-channel start (lrclk 1->0) while en=1.
REQ-019 ARM: at channel start, SHALL load the shift register; at the next bfe SHALL output bit AUDIO_W-1 (one-bclk I2S delay) and go to SHIFT.
REQ-020 SHIFT: SHALL output the next lower bit on each bfe; after AUDIO_W bits SHALL go to PAD.
REQ-021 PAD: SHALL drive 0 until the next channel start, then go to ARM.
REQ-022 At a left start, SHALL pop one FIFO entry and hold its right half for the following right start; the left shift register takes tdata[63:64-AUDIO_W] and the right takes tdata[31:32-AUDIO_W].
REQ-023 At a left start with the FIFO empty, SHALL load zeros for both channels and pulse underrun for one board_clk cycle.
REQ-024 A channel start arriving in SHIFT SHALL abort the current word and reload (ARM), with no bit slip into the new word.
REQ-025 A push and a pop in the same cycle SHALL leave the FIFO count unchanged; a pop when empty SHALL never occur.
REQ-026 en deasserted SHALL take effect at the next left start: the FSM goes to IDLE and the FIFO contents are retained.
REQ-027 ac_pbdat SHALL be registered; latency from bfe to ac_pbdat change SHALL be exactly 1 board_clk cycle after edge detection.

Reset
REQ-028 While reset=1, SHALL hold state IDLE, FIFO empty, shift registers 0, ac_pbdat=0, s_axis_tready=0, underrun=0 and synchronizer flops 0.
REQ-029 Reset mid-word SHALL discard the partial frame; serialization SHALL resume only at the next left start after release.

Configuration
REQ-030 With I2S_TX_UNDERRUN_CNT_EN defined, SHALL add output underrun_cnt (16 bits): saturating count of underrun pulses, cleared by reset.
REQ-031 Without I2S_TX_UNDERRUN_CNT_EN, SHALL omit the port underrun_cnt and its logic; all other behaviour is identical.

Structure
REQ-032 Package sampler_i2s_pkg SHALL hold the FSM state enum (IDLE/ARM/SHIFT/PAD), the 64-bit stereo frame typedef and the LEFT=0 lrclk polarity constant.
REQ-033 The FIFO SHALL be a separate sub-module, i2s_tx_fifo (parameters width 64 and FIFO_DEPTH; push/pop/full/empty).

Verification
REQ-034 AUDIO_W=32, push 64'hcafecafe_deadbeef, then lrclk falls -> pbdat serializes 32'hcafecafe MSB-first starting 1 bclk later, then 32'hdeadbeef after lrclk rises.
REQ-035 AUDIO_W=24, same frame -> left bits 24'hcafeca, then pad zeros; right bits 24'hdeadbe.
REQ-036 tvalid held high, bclk stopped -> exactly 4 frames accepted, then tready=0; one left start -> tready returns to 1 for one push.
REQ-037 Empty FIFO at a left start -> underrun pulses for 1 cycle; 48 zero bits are output; with the macro defined, underrun_cnt=1.
REQ-038 Reset asserted at bit 10 of the left word -> pbdat=0 immediately; after release the next frame starts cleanly at the following lrclk fall.
REQ-039 lrclk toggles after 16 bfe with AUDIO_W=24 -> the word is truncated and the next channel's MSB appears 1 bclk after the toggle.

Source files
------------

// File: rtl/sampler_i2s_pkg.sv
// Shared types and constants for the I2S playback serializer.
package sampler_i2s_pkg;

    localparam int unsigned FRAME_W = 64;
    localparam int unsigned HALF_W  = 32;

    // lrclk level that marks the left channel
    localparam logic LEFT = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } state_t;

    typedef struct packed {
        logic [HALF_W-1:0] left;
        logic [HALF_W-1:0] right;
    } frame_t;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Stereo frame FIFO with first-word fall-through read and wrap-bit pointers.
module i2s_tx_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/i2s_playback_serializer.sv
// I2S playback serializer: AXI-stream stereo frames in, codec serial data out.
// Optional saturating underrun counter output enabled by I2S_TX_UNDERRUN_CNT_EN.
module i2s_playback_serializer
    import sampler_i2s_pkg::*;
#(
    parameter int unsigned AUDIO_W    = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               board_clk,
    input  logic               reset,
    input  logic               en,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [FRAME_W-1:0] s_axis_tdata,
    input  logic               ac_bclk,
    input  logic               ac_pblrc,
    output logic               ac_pbdat,
    output logic               underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]        underrun_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(AUDIO_W);

    logic bclk_s1_q, bclk_s2_q, bclk_d_q;
    logic lrclk_s1_q, lrclk_s2_q, lrclk_smp_q;
    logic bfe, chan_start, left_start;

    state_t             state_q;
    logic [AUDIO_W-1:0] shreg_q;
    logic [AUDIO_W-1:0] right_hold_q;
    logic [CNT_W-1:0]   bitcnt_q;
    logic               pbdat_q;
    logic               underrun_q;

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FRAME_W-1:0] fifo_rdata;
    frame_t             rd_frame;
    logic               unused_frame_bits;

    assign bfe        = bclk_d_q && !bclk_s2_q;
    assign chan_start = bfe && (lrclk_s2_q != lrclk_smp_q);
    assign left_start = chan_start && (lrclk_s2_q == LEFT);

    assign s_axis_tready = en && !fifo_full && !reset;
    assign fifo_push     = s_axis_tvalid && s_axis_tready;
    assign fifo_pop      = left_start && en && !fifo_empty;

    assign rd_frame          = frame_t'(fifo_rdata);
    assign unused_frame_bits = ^rd_frame;

    i2s_tx_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (board_clk),
        .reset_i (reset),
        .push_i  (fifo_push),
        .wdata_i (s_axis_tdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Synchronizers, channel-start detection and the serializer FSM.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            bclk_s1_q    <= 1'b0;
            bclk_s2_q    <= 1'b0;
            bclk_d_q     <= 1'b0;
            lrclk_s1_q   <= 1'b0;
            lrclk_s2_q   <= 1'b0;
            lrclk_smp_q  <= 1'b0;
            state_q      <= IDLE;
            shreg_q      <= '0;
            right_hold_q <= '0;
            bitcnt_q     <= '0;
            pbdat_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            bclk_s1_q  <= ac_bclk;
            bclk_s2_q  <= bclk_s1_q;
            bclk_d_q   <= bclk_s2_q;
            lrclk_s1_q <= ac_pblrc;
            lrclk_s2_q <= lrclk_s1_q;
            underrun_q <= 1'b0;
            if (bfe) lrclk_smp_q <= lrclk_s2_q;

            if (left_start) begin
                // The delay slot before the MSB is always driven low.
                pbdat_q <= 1'b0;
                if (!en) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= ARM;
                    if (fifo_empty) begin
                        shreg_q      <= '0;
                        right_hold_q <= '0;
                        underrun_q   <= 1'b1;
                    end else begin
                        shreg_q      <= rd_frame.left[HALF_W-1 -: AUDIO_W];
                        right_hold_q <= rd_frame.right[HALF_W-1 -: AUDIO_W];
                    end
                end
            end else if (chan_start) begin
                pbdat_q <= 1'b0;
                if (state_q != IDLE) begin
                    state_q <= ARM;
                    shreg_q <= right_hold_q;
                end
            end else if (bfe) begin
                case (state_q)
                    ARM: begin
                        pbdat_q  <= shreg_q[AUDIO_W-1];
                        shreg_q  <= {shreg_q[AUDIO_W-2:0], 1'b0};
                        bitcnt_q <= CNT_W'(AUDIO_W - 1);
                        state_q  <= SHIFT;
                    end
                    SHIFT: begin
                        if (bitcnt_q == '0) begin
                            pbdat_q <= 1'b0;
                            state_q <= PAD;
                        end else begin
                            pbdat_q  <= shreg_q[AUDIO_W-1];
                            shreg_q  <= {shreg_q[AUDIO_W-2:0], 1'b0};
                            bitcnt_q <= bitcnt_q - CNT_W'(1);
                        end
                    end
                    default: pbdat_q <= 1'b0;
                endcase
            end
        end
    end

    assign ac_pbdat = pbdat_q;
    assign underrun = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge board_clk) begin
        if (reset) begin
            underrun_cnt_q <= '0;
        end else if (underrun_q && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
